// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: hazard sequencing for the five-stage pipelined RISC-V core.
// Covers what forwarding cannot: load-use stalls, taken-branch flushes, and
// variable-latency data-memory freezes guarded by a timeout watchdog.
//
// Ports:
//   clk, reset            - clock, synchronous active-high reset
//   Rs1D, Rs2D            - source registers of the instruction in D
//   RdE, LoadE            - destination / is-load of the instruction in E
//   PCSrcE                - taken branch or jump in E
//   MemReqM, MemReadyM    - M-stage access pending / completing this cycle
//   StallF/D/E/M          - hold the F/D/E/M pipeline registers
//   FlushD/E/W            - bubble the D/E/W pipeline registers
//   MemErr                - sticky memory-timeout flag (cleared by reset)
//   StallCount/FlushCount - saturating performance counters
module pipeline_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned TO_W        = 8,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic [4:0]       RdE,
  input  logic             LoadE,
  input  logic             PCSrcE,
  input  logic             MemReqM,
  input  logic             MemReadyM,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushW,
  output logic             MemErr,
  output logic [CNT_W-1:0] StallCount,
  output logic [CNT_W-1:0] FlushCount
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [TO_W-1:0]   r_wait;
  logic [TO_W-1:0]   w_wait_next;
  logic              r_err;
  logic              w_err_set;
  logic              w_load_use;
  logic              w_hazards;
  logic [CNT_W-1:0]  r_scnt;
  logic [CNT_W-1:0]  r_fcnt;

  assign w_load_use = LoadE && (RdE != 5'd0) && ((RdE == Rs1D) || (RdE == Rs2D));

  always_comb begin
    w_next      = r_state;
    w_wait_next = r_wait;
    w_err_set   = 1'b0;
    w_hazards   = 1'b0;
    StallF      = 1'b0;
    StallD      = 1'b0;
    StallE      = 1'b0;
    StallM      = 1'b0;
    FlushD      = 1'b0;
    FlushE      = 1'b0;
    FlushW      = 1'b0;

    if (reset) begin
      FlushD = 1'b1;
      FlushE = 1'b1;
      FlushW = 1'b1;
    end else begin
      case (r_state)
        RUN: begin
          if (MemReqM && !MemReadyM) begin
            {StallF, StallD, StallE, StallM, FlushW} = '1;
            w_next      = MEM_WAIT;
            w_wait_next = TO_W'(1);
          end else begin
            w_hazards = 1'b1;
          end
        end
        MEM_WAIT: begin
          if (MemReadyM) begin
            // Release cycle: the held E-stage instruction is re-evaluated now.
            w_next      = RUN;
            w_wait_next = '0;
            w_hazards   = 1'b1;
          end else begin
            {StallF, StallD, StallE, StallM, FlushW} = '1;
            if (r_wait == TO_W'(MEM_TIMEOUT - 1)) begin
              w_next      = ERROR;
              w_wait_next = '0;
              w_err_set   = 1'b1;
            end else begin
              w_wait_next = r_wait + 1'b1;
            end
          end
        end
        ERROR: begin
          {StallF, StallD, StallE, StallM, FlushW} = '1;
        end
        default: begin
          w_next      = RUN;
          w_wait_next = '0;
        end
      endcase

      if (w_hazards) begin
        if (PCSrcE) begin
          FlushD = 1'b1;
          FlushE = 1'b1;
        end else if (w_load_use) begin
          StallF = 1'b1;
          StallD = 1'b1;
          FlushE = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= RUN;
      r_wait  <= '0;
      r_err   <= 1'b0;
      r_scnt  <= '0;
      r_fcnt  <= '0;
    end else begin
      r_state <= w_next;
      r_wait  <= w_wait_next;
      if (w_err_set) begin
        r_err <= 1'b1;
      end
      if (StallF && (r_scnt != '1)) begin
        r_scnt <= r_scnt + 1'b1;
      end
      if ((FlushD || FlushE) && (r_fcnt != '1)) begin
        r_fcnt <= r_fcnt + 1'b1;
      end
    end
  end

  assign MemErr     = r_err;
  assign StallCount = r_scnt;
  assign FlushCount = r_fcnt;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Randomised scoreboard bench for pipeline_ctrl. Two instances share the
// same stimulus: one with wide counters, one with 4-bit counters to reach
// saturation. A behavioural model tracks true (unbounded) event counts and
// the length of the current unserved memory access; expected counter values
// are the true counts clamped to each instance's maximum.
module tb_pipeline_ctrl;

  localparam int unsigned TO = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] Rs1D, Rs2D, RdE;
  logic       LoadE, PCSrcE, MemReqM, MemReadyM;

  logic        a_SF, a_SD, a_SE, a_SM, a_FD, a_FE, a_FW, a_err;
  logic [31:0] a_sc, a_fc;
  logic        b_SF, b_SD, b_SE, b_SM, b_FD, b_FE, b_FW, b_err;
  logic [3:0]  b_sc, b_fc;

  pipeline_ctrl #(.MEM_TIMEOUT(TO), .TO_W(8), .CNT_W(32)) u_a (
    .clk(clk), .reset(reset), .Rs1D(Rs1D), .Rs2D(Rs2D), .RdE(RdE),
    .LoadE(LoadE), .PCSrcE(PCSrcE), .MemReqM(MemReqM), .MemReadyM(MemReadyM),
    .StallF(a_SF), .StallD(a_SD), .StallE(a_SE), .StallM(a_SM),
    .FlushD(a_FD), .FlushE(a_FE), .FlushW(a_FW), .MemErr(a_err),
    .StallCount(a_sc), .FlushCount(a_fc));

  pipeline_ctrl #(.MEM_TIMEOUT(TO), .TO_W(8), .CNT_W(4)) u_b (
    .clk(clk), .reset(reset), .Rs1D(Rs1D), .Rs2D(Rs2D), .RdE(RdE),
    .LoadE(LoadE), .PCSrcE(PCSrcE), .MemReqM(MemReqM), .MemReadyM(MemReadyM),
    .StallF(b_SF), .StallD(b_SD), .StallE(b_SE), .StallM(b_SM),
    .FlushD(b_FD), .FlushE(b_FE), .FlushW(b_FW), .MemErr(b_err),
    .StallCount(b_sc), .FlushCount(b_fc));

  always #5 clk = ~clk;

  // flags = {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW}
  typedef struct {
    logic [6:0]  flags;
    logic        err;
    logic [63:0] sa, fa, sb, fb;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model state
  int              m_wait = 0;   // consecutive unserved memory cycles so far
  bit              m_err  = 1'b0;
  longint unsigned m_scnt = 0;
  longint unsigned m_fcnt = 0;

  function automatic logic [63:0] clamp(input longint unsigned v, input int w);
    longint unsigned mx;
    mx = (w >= 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
    return (v > mx) ? mx : v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic step(input bit rst, input bit [4:0] r1, input bit [4:0] r2,
                      input bit [4:0] rd, input bit ld, input bit pc,
                      input bit rq, input bit ry);
    bit         lu, memst;
    logic [6:0] f;
    exp_t       e;
    @(posedge clk);
    #1;
    reset = rst; Rs1D = r1; Rs2D = r2; RdE = rd;
    LoadE = ld; PCSrcE = pc; MemReqM = rq; MemReadyM = ry;

    lu    = ld && (rd != 0) && ((rd == r1) || (rd == r2));
    memst = !rst && !m_err && !ry && ((m_wait > 0) || rq);
    if (rst)        f = 7'b0000111;
    else if (m_err) f = 7'b1111001;
    else if (memst) f = 7'b1111001;
    else if (pc)    f = 7'b0000110;
    else if (lu)    f = 7'b1100010;
    else            f = 7'b0000000;

    e.flags = f;
    e.err   = m_err;
    e.sa    = clamp(m_scnt, 32);
    e.fa    = clamp(m_fcnt, 32);
    e.sb    = clamp(m_scnt, 4);
    e.fb    = clamp(m_fcnt, 4);
    q.push_back(e);

    if (rst) begin
      m_wait = 0; m_err = 1'b0; m_scnt = 0; m_fcnt = 0;
    end else begin
      if (f[6]) m_scnt++;
      if (f[2] || f[1]) m_fcnt++;
      if (!m_err) begin
        if (memst) begin
          m_wait++;
          if (m_wait >= TO) begin
            m_err  = 1'b1;
            m_wait = 0;
          end
        end else begin
          m_wait = 0;
        end
      end
    end
  endtask

  // Monitor: every cycle is an output cycle for this controller.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("flags_a", {57'd0, a_SF, a_SD, a_SE, a_SM, a_FD, a_FE, a_FW}, {57'd0, e.flags});
      chk("flags_b", {57'd0, b_SF, b_SD, b_SE, b_SM, b_FD, b_FE, b_FW}, {57'd0, e.flags});
      chk("memerr_a", {63'd0, a_err}, {63'd0, e.err});
      chk("memerr_b", {63'd0, b_err}, {63'd0, e.err});
      chk("stallcnt_a", {32'd0, a_sc}, e.sa);
      chk("flushcnt_a", {32'd0, a_fc}, e.fa);
      chk("stallcnt_b", {60'd0, b_sc}, e.sb);
      chk("flushcnt_b", {60'd0, b_fc}, e.fb);
    end
  end

  initial begin
    bit slow;
    reset = 1'b1; Rs1D = '0; Rs2D = '0; RdE = '0;
    LoadE = 1'b0; PCSrcE = 1'b0; MemReqM = 1'b0; MemReadyM = 1'b0;

    // Reset state
    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    // Load-use on rs1, then on rs2
    step(0, 5, 0, 5, 1, 0, 0, 0);
    step(0, 1, 7, 7, 1, 0, 0, 0);
    // x0 exemption
    step(0, 3, 0, 0, 1, 0, 0, 0);
    // Branch over load-use
    step(0, 5, 0, 5, 1, 1, 0, 0);
    // Memory wait of 3 cycles, release with branch pending
    step(0, 0, 0, 0, 0, 1, 1, 0);
    step(0, 0, 0, 0, 0, 1, 1, 0);
    step(0, 0, 0, 0, 0, 1, 1, 0);
    step(0, 0, 0, 0, 0, 1, 1, 1);
    // Memory wait released with load-use pending
    step(0, 6, 0, 6, 1, 0, 1, 0);
    step(0, 6, 0, 6, 1, 0, 1, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    // Timeout: 4 unserved cycles, then frozen; ready pulses ignored
    for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 4; i++) step(0, 2, 0, 2, 1, 1, 1, i % 2);
    // Stall held long enough to saturate the 4-bit counter
    for (int i = 0; i < 20; i++) step(0, 0, 0, 0, 0, 0, 1, 0);
    step(1, 0, 0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    // Timeout boundary: 3 unserved cycles must not error
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0, 1, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    // Reset in the middle of a memory wait
    step(0, 0, 0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0, 1, 0);
    step(1, 0, 0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);

    // Randomised traffic, alternating fast and slow memory phases
    slow = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      bit rst, ry;
      if (i % 200 == 0) slow = ~slow;
      rst = ($urandom_range(0, slow ? 59 : 199) == 0);
      ry  = slow ? ($urandom_range(0, 99) < 15) : ($urandom_range(0, 99) < 70);
      step(rst, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)), ry);
    end

    @(negedge clk);
    #1;
    n_checks++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
